// File: rtl/rs_wakeup_select.sv
// rs_wakeup_select: reservation station for ALU/branch ops.
// Holds dispatched ops until both operands are available, snoops CDB_PORTS result
// broadcasts for wakeup, and issues the oldest ready entry over a valid/ready handshake.
// Ports:
//   clk_in, rst_n_in       clock (rising edge), asynchronous active-low reset
//   rdy_in                 global enable; low freezes all state
//   flush_in               mispredict flush, clears every entry
//   dec_*                  dispatch request/handshake and op payload from the decoder
//   cdb_*                  packed broadcast channels; channel i at [i*W +: W]
//   iss_*                  oldest ready entry presented to the ALU, valid/ready handshake
//   occupancy              number of valid entries
module rs_wakeup_select #(
   parameter int unsigned RS_SIZE   = 8,
   parameter int unsigned RS_WIDTH  = 3,
   parameter int unsigned ROB_WIDTH = 4,
   parameter int unsigned CDB_PORTS = 2,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned OP_WIDTH  = 5
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          rdy_in,
   input  logic                          flush_in,
   input  logic                          dec_valid,
   output logic                          dec_ready,
   input  logic [OP_WIDTH-1:0]           dec_op,
   input  logic [XLEN-1:0]               dec_vj,
   input  logic [XLEN-1:0]               dec_vk,
   input  logic                          dec_qj_pend,
   input  logic                          dec_qk_pend,
   input  logic [ROB_WIDTH-1:0]          dec_qj,
   input  logic [ROB_WIDTH-1:0]          dec_qk,
   input  logic [XLEN-1:0]               dec_imm,
   input  logic [ROB_WIDTH-1:0]          dec_rob_id,
   input  logic [CDB_PORTS-1:0]          cdb_valid,
   input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_rob_id,
   input  logic [CDB_PORTS*XLEN-1:0]     cdb_data,
   output logic                          iss_valid,
   input  logic                          iss_ready,
   output logic [OP_WIDTH-1:0]           iss_op,
   output logic [XLEN-1:0]               iss_vj,
   output logic [XLEN-1:0]               iss_vk,
   output logic [XLEN-1:0]               iss_imm,
   output logic [ROB_WIDTH-1:0]          iss_rob_id,
   output logic [RS_WIDTH:0]             occupancy
);

   localparam logic [RS_WIDTH:0] FULL_COUNT = (RS_WIDTH + 1)'(RS_SIZE);

   logic [RS_SIZE-1:0]   valid_q, valid_d, pj_q, pj_d, pk_q, pk_d, ready;
   logic [OP_WIDTH-1:0]  op_q   [RS_SIZE];
   logic [OP_WIDTH-1:0]  op_d   [RS_SIZE];
   logic [XLEN-1:0]      vj_q   [RS_SIZE];
   logic [XLEN-1:0]      vj_d   [RS_SIZE];
   logic [XLEN-1:0]      vk_q   [RS_SIZE];
   logic [XLEN-1:0]      vk_d   [RS_SIZE];
   logic [XLEN-1:0]      imm_q  [RS_SIZE];
   logic [XLEN-1:0]      imm_d  [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj_d   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk_d   [RS_SIZE];
   logic [ROB_WIDTH-1:0] rob_q  [RS_SIZE];
   logic [ROB_WIDTH-1:0] rob_d  [RS_SIZE];
   // older_q[i][j] = 1 when entry i was dispatched before entry j
   logic [RS_SIZE-1:0]   older_q [RS_SIZE];
   logic [RS_SIZE-1:0]   older_d [RS_SIZE];
   logic [RS_WIDTH:0]    occ_q, occ_d;

   logic [RS_WIDTH-1:0]  sel_idx, free_idx;
   logic                 any_ready, blocked, dispatch, issue;

   assign ready     = valid_q & ~pj_q & ~pk_q;
   assign any_ready = |ready;
   assign dec_ready = rdy_in && (occ_q != FULL_COUNT);
   assign iss_valid = rdy_in && any_ready && !flush_in;
   assign dispatch  = dec_valid && dec_ready && !flush_in;
   assign issue     = iss_valid && iss_ready;
   assign occupancy = occ_q;

   assign iss_op     = op_q[sel_idx];
   assign iss_vj     = vj_q[sel_idx];
   assign iss_vk     = vk_q[sel_idx];
   assign iss_imm    = imm_q[sel_idx];
   assign iss_rob_id = rob_q[sel_idx];

   // Oldest ready entry: no other ready entry has its older bit set against it.
   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      blocked  = 1'b0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         blocked = 1'b0;
         for (int j = 0; j < RS_SIZE; j++) begin
            if (ready[j] && older_q[j][i]) blocked = 1'b1;
         end
         if (ready[i] && !blocked) sel_idx = RS_WIDTH'(i);
         if (!valid_q[i]) free_idx = RS_WIDTH'(i);
      end
   end

   always_comb begin
      valid_d = valid_q;
      pj_d    = pj_q;
      pk_d    = pk_q;
      occ_d   = occ_q;
      for (int i = 0; i < RS_SIZE; i++) begin
         op_d[i]    = op_q[i];
         vj_d[i]    = vj_q[i];
         vk_d[i]    = vk_q[i];
         imm_d[i]   = imm_q[i];
         qj_d[i]    = qj_q[i];
         qk_d[i]    = qk_q[i];
         rob_d[i]   = rob_q[i];
         older_d[i] = older_q[i];
      end
      if (rdy_in) begin
         if (flush_in) begin
            valid_d = '0;
            occ_d   = '0;
         end else begin
            // Channels scanned high to low so the lowest matching channel wins.
            for (int i = 0; i < RS_SIZE; i++) begin
               for (int c = CDB_PORTS - 1; c >= 0; c--) begin
                  if (valid_q[i] && pj_q[i] && cdb_valid[c] &&
                      cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == qj_q[i]) begin
                     vj_d[i] = cdb_data[c*XLEN +: XLEN];
                     pj_d[i] = 1'b0;
                  end
                  if (valid_q[i] && pk_q[i] && cdb_valid[c] &&
                      cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == qk_q[i]) begin
                     vk_d[i] = cdb_data[c*XLEN +: XLEN];
                     pk_d[i] = 1'b0;
                  end
               end
            end
            if (issue) valid_d[sel_idx] = 1'b0;
            if (dispatch) begin
               valid_d[free_idx] = 1'b1;
               op_d[free_idx]    = dec_op;
               vj_d[free_idx]    = dec_vj;
               vk_d[free_idx]    = dec_vk;
               pj_d[free_idx]    = dec_qj_pend;
               pk_d[free_idx]    = dec_qk_pend;
               qj_d[free_idx]    = dec_qj;
               qk_d[free_idx]    = dec_qk;
               imm_d[free_idx]   = dec_imm;
               rob_d[free_idx]   = dec_rob_id;
               // Dispatch-cycle bypass of a result broadcast in the same cycle.
               for (int c = CDB_PORTS - 1; c >= 0; c--) begin
                  if (dec_qj_pend && cdb_valid[c] &&
                      cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == dec_qj) begin
                     vj_d[free_idx] = cdb_data[c*XLEN +: XLEN];
                     pj_d[free_idx] = 1'b0;
                  end
                  if (dec_qk_pend && cdb_valid[c] &&
                      cdb_rob_id[c*ROB_WIDTH +: ROB_WIDTH] == dec_qk) begin
                     vk_d[free_idx] = cdb_data[c*XLEN +: XLEN];
                     pk_d[free_idx] = 1'b0;
                  end
               end
               for (int j = 0; j < RS_SIZE; j++) older_d[j][free_idx] = valid_q[j];
               older_d[free_idx] = '0;
            end
            if (dispatch && !issue)      occ_d = occ_q + 1'b1;
            else if (!dispatch && issue) occ_d = occ_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= '0;
         pj_q    <= '0;
         pk_q    <= '0;
         occ_q   <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]    <= '0;
            vj_q[i]    <= '0;
            vk_q[i]    <= '0;
            imm_q[i]   <= '0;
            qj_q[i]    <= '0;
            qk_q[i]    <= '0;
            rob_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         pj_q    <= pj_d;
         pk_q    <= pk_d;
         occ_q   <= occ_d;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]    <= op_d[i];
            vj_q[i]    <= vj_d[i];
            vk_q[i]    <= vk_d[i];
            imm_q[i]   <= imm_d[i];
            qj_q[i]    <= qj_d[i];
            qk_q[i]    <= qk_d[i];
            rob_q[i]   <= rob_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rs_wakeup_select.sv
module tb_rs_wakeup_select;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, flush_in;
   logic        dec_valid, dec_ready, dec_qj_pend, dec_qk_pend;
   logic [4:0]  dec_op, iss_op;
   logic [31:0] dec_vj, dec_vk, dec_imm, iss_vj, iss_vk, iss_imm;
   logic [3:0]  dec_qj, dec_qk, dec_rob_id, iss_rob_id;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_rob_id;
   logic [63:0] cdb_data;
   logic        iss_valid, iss_ready;
   logic [3:0]  occupancy;

   typedef struct packed {
      logic [3:0]  rob;
      logic [4:0]  op;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [31:0] imm;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   rs_wakeup_select dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
      .dec_vj(dec_vj), .dec_vk(dec_vk), .dec_qj_pend(dec_qj_pend),
      .dec_qk_pend(dec_qk_pend), .dec_qj(dec_qj), .dec_qk(dec_qk),
      .dec_imm(dec_imm), .dec_rob_id(dec_rob_id),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
      .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm),
      .iss_rob_id(iss_rob_id), .occupancy(occupancy)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic exp_t mk(input logic [3:0] rob, input logic [31:0] vj,
                               input logic [31:0] vk);
      exp_t e;
      e.rob = rob;
      e.op  = 5'(rob) + 5'd1;
      e.vj  = vj;
      e.vk  = vk;
      e.imm = 32'h1000 + 32'(rob);
      return e;
   endfunction

   // Drives one dispatch for a single cycle; op and imm derive from the rob tag.
   task automatic disp(input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                       input logic qjp, input logic [3:0] qj,
                       input logic qkp, input logic [3:0] qk);
      dec_valid   = 1'b1;
      dec_rob_id  = rob;
      dec_op      = 5'(rob) + 5'd1;
      dec_imm     = 32'h1000 + 32'(rob);
      dec_vj      = vj;
      dec_vk      = vk;
      dec_qj_pend = qjp;
      dec_qj      = qj;
      dec_qk_pend = qkp;
      dec_qk      = qk;
      tick();
      dec_valid   = 1'b0;
   endtask

   task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                      input logic [3:0] t1, input logic [31:0] d1);
      cdb_valid  = v;
      cdb_rob_id = {t1, t0};
      cdb_data   = {d1, d0};
   endtask

   // Scoreboard: every accepted issue must match the next expected packet.
   always @(negedge clk_in) begin
      if (rst_n_in && iss_valid && iss_ready) begin
         if (sb.size() == 0) begin
            check_val("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("iss_rob", 64'(iss_rob_id), 64'(e.rob));
            check_val("iss_op", 64'(iss_op), 64'(e.op));
            check_val("iss_vj", 64'(iss_vj), 64'(e.vj));
            check_val("iss_vk", 64'(iss_vk), 64'(e.vk));
            check_val("iss_imm", 64'(iss_imm), 64'(e.imm));
         end
      end
   end

   initial begin
      rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; iss_ready = 1'b1;
      dec_valid = 1'b0; dec_op = '0; dec_vj = '0; dec_vk = '0; dec_imm = '0;
      dec_qj_pend = 1'b0; dec_qk_pend = 1'b0; dec_qj = '0; dec_qk = '0; dec_rob_id = '0;
      cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      #2;
      check_val("rst_occ", 64'(occupancy), 64'd0);
      check_val("rst_iss_valid", 64'(iss_valid), 64'd0);
      check_val("rst_dec_ready", 64'(dec_ready), 64'd1);
      tick();
      tick();
      rst_n_in = 1'b1;
      tick();

      // Single ready op issues the cycle after dispatch.
      sb.push_back(mk(4'd3, 32'd5, 32'd7));
      disp(4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
      check_val("t1_occ1", 64'(occupancy), 64'd1);
      check_val("t1_valid", 64'(iss_valid), 64'd1);
      tick();
      check_val("t1_occ0", 64'(occupancy), 64'd0);
      check_val("t1_empty", 64'(iss_valid), 64'd0);

      // Younger ready op overtakes an older pending one.
      disp(4'd1, 32'd0, 32'd2, 1'b1, 4'd9, 1'b0, 4'd0);
      sb.push_back(mk(4'd2, 32'd10, 32'd20));
      disp(4'd2, 32'd10, 32'd20, 1'b0, 4'd0, 1'b0, 4'd0);
      check_val("t2_b_first", 64'(iss_rob_id), 64'd2);
      cdb(2'b10, 4'd0, 32'd0, 4'd9, 32'hABCD);
      sb.push_back(mk(4'd1, 32'hABCD, 32'd2));
      tick();
      cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check_val("t2_a_woken", 64'(iss_vj), 64'hABCD);
      tick();
      check_val("t2_occ", 64'(occupancy), 64'd0);

      // Both channels carry the same tag: channel 0 data wins.
      disp(4'd5, 32'd0, 32'd3, 1'b1, 4'd6, 1'b0, 4'd0);
      check_val("t2_pending", 64'(iss_valid), 64'd0);
      cdb(2'b11, 4'd6, 32'h60, 4'd6, 32'h61);
      sb.push_back(mk(4'd5, 32'h60, 32'd3));
      tick();
      cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      tick();

      // Dispatch-cycle bypass on the k operand.
      cdb(2'b01, 4'd4, 32'h11, 4'd0, 32'd0);
      sb.push_back(mk(4'd6, 32'd8, 32'h11));
      disp(4'd6, 32'd8, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4);
      cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check_val("t3_bypass_valid", 64'(iss_valid), 64'd1);
      check_val("t3_bypass_vk", 64'(iss_vk), 64'h11);
      tick();

      // Fill all entries with pending ops; entry k waits on tag k+8.
      for (int k = 0; k < 8; k++) begin
         disp(4'(k), 32'd0, 32'(k), 1'b1, 4'(k + 8), 1'b0, 4'd0);
      end
      check_val("t4_full_occ", 64'(occupancy), 64'd8);
      check_val("t4_full_ready", 64'(dec_ready), 64'd0);
      disp(4'd15, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
      check_val("t4_ignored", 64'(occupancy), 64'd8);
      check_val("t4_none_ready", 64'(iss_valid), 64'd0);
      cdb(2'b11, 4'd13, 32'h55, 4'd10, 32'h22);
      sb.push_back(mk(4'd2, 32'h22, 32'd2));
      sb.push_back(mk(4'd5, 32'h55, 32'd5));
      tick();
      cdb(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
      check_val("t4_older_first", 64'(iss_rob_id), 64'd2);
      tick();
      check_val("t4_then_younger", 64'(iss_rob_id), 64'd5);
      tick();
      check_val("t4_occ6", 64'(occupancy), 64'd6);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      check_val("t4_flushed", 64'(occupancy), 64'd0);

      // Stall: presented op stays stable, then flush clears it.
      iss_ready = 1'b0;
      disp(4'd7, 32'h77, 32'h78, 1'b0, 4'd0, 1'b0, 4'd0);
      for (int c = 0; c < 3; c++) begin
         check_val("t5_hold_valid", 64'(iss_valid), 64'd1);
         check_val("t5_hold_rob", 64'(iss_rob_id), 64'd7);
         check_val("t5_hold_vj", 64'(iss_vj), 64'h77);
         check_val("t5_hold_occ", 64'(occupancy), 64'd1);
         tick();
      end
      flush_in = 1'b1;
      #1;
      check_val("t5_flush_cycle_valid", 64'(iss_valid), 64'd0);
      tick();
      flush_in = 1'b0;
      check_val("t5_flush_occ", 64'(occupancy), 64'd0);
      check_val("t5_flush_valid", 64'(iss_valid), 64'd0);

      // rdy_in low freezes the station.
      rdy_in = 1'b0;
      #1;
      check_val("rdy_dec_ready", 64'(dec_ready), 64'd0);
      disp(4'd8, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
      rdy_in = 1'b1;
      check_val("rdy_frozen_occ", 64'(occupancy), 64'd0);

      // Asynchronous reset mid-cycle with four entries held.
      for (int k = 0; k < 3; k++) begin
         disp(4'(k + 9), 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0);
      end
      disp(4'd12, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
      check_val("t6_pre_occ", 64'(occupancy), 64'd4);
      check_val("t6_pre_valid", 64'(iss_valid), 64'd1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check_val("t6_async_occ", 64'(occupancy), 64'd0);
      check_val("t6_async_valid", 64'(iss_valid), 64'd0);
      tick();
      rst_n_in = 1'b1;
      iss_ready = 1'b1;
      tick();
      check_val("t6_post_ready", 64'(dec_ready), 64'd1);
      check_val("t6_post_occ", 64'(occupancy), 64'd0);

      check_val("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
